// File: rtl/serial_tx_sched.sv
// rtl/serial_tx_sched.sv - round-robin byte scheduler for the shared serial transmit path
// Optional feature macro: TX_TIMEOUT_EN (SEND watchdog with sticky timeoutErr).
module serial_tx_sched #(
  parameter int NREQ           = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   reqVec,
  input  logic [8*NREQ-1:0] reqData,
  input  logic              charSent,
  output logic [7:0]        dataToSent,
  output logic              transEnable,
  output logic [NREQ-1:0]   ackVec,
  output logic [2:0]        grantIdx,
  output logic              busy,
  output logic              timeoutErr
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, ACK, GAP} state_t;

  state_t          state_q;
  logic [7:0]      data_q;
  logic            te_q;
  logic [NREQ-1:0] ack_q;
  logic [2:0]      grant_q;
  logic [2:0]      ptr_q;
  logic [GW-1:0]   gap_q;
  logic            charsent_q;
  logic            sent_edge;

  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [7:0]      pick_data;
  logic [NREQ-1:0] ack_d;
  logic [2:0]      ptr_d;

`ifdef TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_q;
  logic          terr_q;
`endif

  assign sent_edge = charSent & ~charsent_q;

  // Round-robin pick: lowest offset from the pointer wins, so iterate downward and let it overwrite.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    pick_data  = 8'h00;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (reqVec[j]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(j);
        pick_data  = reqData[8*j +: 8];
      end
    end
  end

  // One-hot ack for the current grant and the pointer value that follows it.
  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == grant_q) ack_d[i] = 1'b1;
    end
    ptr_d = (grant_q == 3'(NREQ - 1)) ? 3'd0 : grant_q + 3'd1;
  end

  // Scheduler FSM: IDLE -> SEND (hold transEnable) -> ACK (one-cycle pulse) -> GAP -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      te_q       <= 1'b0;
      ack_q      <= '0;
      grant_q    <= 3'd0;
      ptr_q      <= 3'd0;
      gap_q      <= '0;
      charsent_q <= 1'b0;
`ifdef TX_TIMEOUT_EN
      to_q       <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      charsent_q <= charSent;
      ack_q      <= '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            data_q  <= pick_data;
            grant_q <= pick_idx;
            te_q    <= 1'b1;
            state_q <= SEND;
`ifdef TX_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        SEND: begin
          if (sent_edge) begin
            te_q    <= 1'b0;
            ack_q   <= ack_d;
            state_q <= ACK;
          end
`ifdef TX_TIMEOUT_EN
          else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            te_q    <= 1'b0;
            ack_q   <= ack_d;
            terr_q  <= 1'b1;
            state_q <= ACK;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        ACK: begin
          ptr_q   <= ptr_d;
          gap_q   <= '0;
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= IDLE;
          else                               gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataToSent  = data_q;
  assign transEnable = te_q;
  assign ackVec      = ack_q;
  assign grantIdx    = grant_q;
  assign busy        = (state_q != IDLE);
`ifdef TX_TIMEOUT_EN
  assign timeoutErr  = terr_q;
`else
  assign timeoutErr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_sched.sv
// tb/tb_serial_tx_sched.sv - directed self-checking bench for serial_tx_sched
module tb_serial_tx_sched;
  localparam int NREQ = 4;
  localparam int GAP  = 16;
  localparam int TO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  reqVec = 4'h0;
  logic [31:0] reqData = 32'h0;
  logic        charSent = 1'b0;
  logic [7:0]  dataToSent;
  logic        transEnable;
  logic [3:0]  ackVec;
  logic [2:0]  grantIdx;
  logic        busy;
  logic        timeoutErr;

  int n_cmp = 0;
  int n_bad = 0;

  serial_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .reqVec(reqVec), .reqData(reqData), .charSent(charSent),
    .dataToSent(dataToSent), .transEnable(transEnable), .ackVec(ackVec),
    .grantIdx(grantIdx), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_idle;
    int c = 0;
    while (busy !== 1'b0 && c < 100) begin tick(); c++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle: busy=%b want 0 within 100 cycles", busy); end
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_cmp++; if (transEnable !== 1'b0) begin n_bad++; $display("FAIL rst_te: got %b want 0", transEnable); end
    n_cmp++; if (dataToSent !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", dataToSent); end
    n_cmp++; if (ackVec !== 4'h0) begin n_bad++; $display("FAIL rst_ack: got %b want 0000", ackVec); end
    n_cmp++; if (grantIdx !== 3'd0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", grantIdx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (timeoutErr !== 1'b0) begin n_bad++; $display("FAIL rst_terr: got %b want 0", timeoutErr); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    reqData = 32'h00000041;
    reqVec  = 4'b0001;
    tick();
    n_cmp++; if (transEnable !== 1'b1) begin n_bad++; $display("FAIL single_te: got %b want 1", transEnable); end
    n_cmp++; if (dataToSent !== 8'h41) begin n_bad++; $display("FAIL single_data: got %h want 41", dataToSent); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    charSent = 1'b1;
    tick();
    n_cmp++; if (ackVec !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b want 0001", ackVec); end
    n_cmp++; if (transEnable !== 1'b0) begin n_bad++; $display("FAIL single_te_drop: got %b want 0", transEnable); end
    charSent = 1'b0;
    reqVec   = 4'b0000;
    tick();
    n_cmp++; if (ackVec !== 4'b0000) begin n_bad++; $display("FAIL single_ack_width: got %b want 0000", ackVec); end
    repeat (GAP - 1) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_gap_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_gap_end: got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    int cnt;
    int g;
    logic [7:0] ed;
    do_reset();
    reqData = 32'h40302010;
    reqVec  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      g   = k % NREQ;
      ed  = 8'((g + 1) * 16);
      cnt = 0;
      while (transEnable !== 1'b1 && cnt < 100) begin tick(); cnt++; end
      n_cmp++; if (cnt !== ((k == 0) ? 1 : GAP + 2)) begin n_bad++; $display("FAIL rr_latency[%0d]: got %0d want %0d", k, cnt, (k == 0) ? 1 : GAP + 2); end
      n_cmp++; if (grantIdx !== 3'(g)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grantIdx, g); end
      n_cmp++; if (dataToSent !== ed) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, dataToSent, ed); end
      charSent = 1'b1;
      tick();
      charSent = 1'b0;
      n_cmp++; if (ackVec !== 4'(1 << g)) begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ackVec, 4'(1 << g)); end
    end
    reqVec = 4'h0;
    wait_idle();
  endtask

  task automatic test_charsent_high;
    int n_acks;
    charSent = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ch_idle_edge: busy=%b want 0", busy); end
    reqData = 32'h00005500;
    reqVec  = 4'b0010;
    tick();
    n_cmp++; if (grantIdx !== 3'd1) begin n_bad++; $display("FAIL ch_grant: got %0d want 1", grantIdx); end
    n_acks = 0;
    repeat (6) begin tick(); if (ackVec !== 4'h0) n_acks++; end
    n_cmp++; if (n_acks !== 0) begin n_bad++; $display("FAIL ch_no_early_ack: got %0d acks want 0", n_acks); end
    n_cmp++; if (transEnable !== 1'b1) begin n_bad++; $display("FAIL ch_te_wait: got %b want 1", transEnable); end
    charSent = 1'b0;
    tick();
    charSent = 1'b1;
    tick();
    n_cmp++; if (ackVec !== 4'b0010) begin n_bad++; $display("FAIL ch_ack: got %b want 0010", ackVec); end
    reqVec = 4'h0;
    n_acks = 0;
    repeat (30) begin tick(); if (ackVec !== 4'h0) n_acks++; end
    n_cmp++; if (n_acks !== 0) begin n_bad++; $display("FAIL ch_single_ack: got %0d extra acks want 0", n_acks); end
    charSent = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_send;
    reqData = 32'h00770000;
    reqVec  = 4'b0100;
    tick();
    n_cmp++; if (transEnable !== 1'b1) begin n_bad++; $display("FAIL rms_te: got %b want 1", transEnable); end
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (transEnable !== 1'b0) begin n_bad++; $display("FAIL rms_te_async: got %b want 0", transEnable); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rms_busy_async: got %b want 0", busy); end
    tick();
    tick();
    n_cmp++; if (ackVec !== 4'h0) begin n_bad++; $display("FAIL rms_no_ack: got %b want 0000", ackVec); end
    rst     = 1'b1;
    reqVec  = 4'hF;
    reqData = 32'h44332211;
    tick();
    n_cmp++; if (grantIdx !== 3'd0) begin n_bad++; $display("FAIL rms_ptr0: got %0d want 0", grantIdx); end
    n_cmp++; if (dataToSent !== 8'h11) begin n_bad++; $display("FAIL rms_data: got %h want 11", dataToSent); end
    charSent = 1'b1;
    tick();
    charSent = 1'b0;
    n_cmp++; if (ackVec !== 4'b0001) begin n_bad++; $display("FAIL rms_ack: got %b want 0001", ackVec); end
    reqVec = 4'h0;
    wait_idle();
  endtask

  task automatic test_drop_mid_send;
    reqData = 32'h00990000;
    reqVec  = 4'b0100;
    tick();
    n_cmp++; if (grantIdx !== 3'd2) begin n_bad++; $display("FAIL drop_grant: got %0d want 2", grantIdx); end
    reqVec = 4'h0;
    repeat (2) tick();
    n_cmp++; if (transEnable !== 1'b1) begin n_bad++; $display("FAIL drop_te: got %b want 1", transEnable); end
    n_cmp++; if (dataToSent !== 8'h99) begin n_bad++; $display("FAIL drop_data: got %h want 99", dataToSent); end
    charSent = 1'b1;
    tick();
    charSent = 1'b0;
    n_cmp++; if (ackVec !== 4'b0100) begin n_bad++; $display("FAIL drop_ack: got %b want 0100", ackVec); end
    wait_idle();
    reqData = 32'hDDCCBBAA;
    reqVec  = 4'hF;
    tick();
    n_cmp++; if (grantIdx !== 3'd3) begin n_bad++; $display("FAIL drop_ptr3: got %0d want 3", grantIdx); end
    n_cmp++; if (dataToSent !== 8'hDD) begin n_bad++; $display("FAIL drop_next_data: got %h want DD", dataToSent); end
    charSent = 1'b1;
    tick();
    charSent = 1'b0;
    n_cmp++; if (ackVec !== 4'b1000) begin n_bad++; $display("FAIL drop_next_ack: got %b want 1000", ackVec); end
    reqVec = 4'h0;
    wait_idle();
  endtask

  task automatic test_timeout;
    int cyc;
    reqData = 32'h000000E1;
    reqVec  = 4'b0001;
    tick();
`ifdef TX_TIMEOUT_EN
    cyc = 1;
    while (ackVec === 4'h0 && cyc < 200) begin tick(); cyc++; end
    n_cmp++; if (cyc !== TO + 1) begin n_bad++; $display("FAIL to_ack_cycle: got %0d want %0d", cyc, TO + 1); end
    n_cmp++; if (ackVec !== 4'b0001) begin n_bad++; $display("FAIL to_ack: got %b want 0001", ackVec); end
    n_cmp++; if (timeoutErr !== 1'b1) begin n_bad++; $display("FAIL to_err_set: got %b want 1", timeoutErr); end
    reqVec = 4'h0;
    wait_idle();
    reqVec = 4'b0001;
    tick();
    charSent = 1'b1;
    tick();
    charSent = 1'b0;
    n_cmp++; if (ackVec !== 4'b0001) begin n_bad++; $display("FAIL to_normal_ack: got %b want 0001", ackVec); end
    n_cmp++; if (timeoutErr !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %b want 1", timeoutErr); end
`else
    cyc = 0;
    repeat (300) begin tick(); if (ackVec !== 4'h0) cyc++; end
    n_cmp++; if (cyc !== 0) begin n_bad++; $display("FAIL to_none_ack: got %0d acks want 0", cyc); end
    n_cmp++; if (transEnable !== 1'b1) begin n_bad++; $display("FAIL to_none_te: got %b want 1", transEnable); end
    n_cmp++; if (timeoutErr !== 1'b0) begin n_bad++; $display("FAIL to_none_err: got %b want 0", timeoutErr); end
    charSent = 1'b1;
    tick();
    charSent = 1'b0;
    n_cmp++; if (ackVec !== 4'b0001) begin n_bad++; $display("FAIL to_none_final_ack: got %b want 0001", ackVec); end
`endif
    reqVec = 4'h0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_charsent_high();
    test_reset_mid_send();
    test_drop_mid_send();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_sched.md
Name: serial_tx_sched

Overview:
- Round-robin scheduler that shares the single serial transmit path among NREQ byte requesters.
- Sits between producer blocks (memory reader, NIOS bridge, status reporter) and the transmitter input pair dataToSent/transEnable.
- Latches one requester's byte and holds transEnable until the transmitter reports charSent.
- Acknowledges the requester, then enforces an inter-character gap before re-arbitrating.

Parameters:
- NREQ, 4: number of requesters (2..8).
- GAP_CYCLES, 16: idle clk cycles between charSent and the next arbitration (>=1).
- TIMEOUT_CYCLES, 200000: SEND cycles before abort; used only with TX_TIMEOUT_EN.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- reqVec  input  NREQ  per-requester request; held high until the matching ackVec pulse.
- reqData  input  8*NREQ  byte for requester i is at [8i+7:8i]; stable while reqVec[i] is high.
- charSent  input  1  transmitter completion level; the scheduler uses only its rising edge.
- dataToSent  output  8  byte to the transmitter.
- transEnable  output  1  transmit request level.
- ackVec  output  NREQ  one-hot, one-cycle completion pulse.
- grantIdx  output  3  index of the current or last granted requester.
- busy  output  1  high in any state except IDLE.
- timeoutErr  output  1  sticky timeout flag (TX_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, dataToSent=0, transEnable=0, ackVec=0, grantIdx=0, busy=0, timeoutErr=0.
  - Round-robin pointer=0, gap and timeout counters=0, charSent edge register=0.
- Edge detect: register charSent each cycle; sentEdge = charSent & ~charSent_q.
- FSM:
  - IDLE:
    - If reqVec != 0, pick the first set bit searching from pointer upward, wrapping modulo NREQ.
    - Latch that byte into dataToSent and the index into grantIdx, then go to SEND.
    - Arbitration and latch take exactly 1 cycle.
  - SEND:
    - transEnable=1, held at level.
    - On sentEdge, go to ACK.
    - sentEdge in the same cycle SEND is entered counts.
  - ACK:
    - transEnable=0; ackVec[grantIdx]=1 for exactly 1 cycle.
    - pointer=(grantIdx+1) mod NREQ; go to GAP.
  - GAP:
    - Count GAP_CYCLES cycles, then go to IDLE.
    - New requests are not sampled during GAP.
- Latency:
  - reqVec rise while IDLE -> transEnable high on the next edge.
  - sentEdge -> ackVec pulse 1 cycle later.
  - ack -> earliest next transEnable is GAP_CYCLES+2 cycles later.
- Fairness: with all requesters permanently asserted, grants rotate 0,1,...,NREQ-1,0,...
- Boundary conditions:
  - Requester drops reqVec mid-SEND: the byte already latched is still sent and ack is still pulsed (requester ignores it).
  - charSent already high when SEND is entered: no edge, so the scheduler waits for the next rising edge.
  - charSent edge outside SEND: ignored.
  - Reset mid-SEND: transEnable drops asynchronously and no ack is issued.
  - Single requester: granted every round, no starvation.
- dataToSent holds its value from the latch until the next grant.

Optional Feature:
- Macro: TX_TIMEOUT_EN
- Defined:
  - A counter runs in SEND and clears on SEND entry.
  - When it reaches TIMEOUT_CYCLES, go to ACK, still pulsing ack so the requester is released.
  - timeoutErr is set and stays set until reset.
- Undefined:
  - No counter; SEND waits indefinitely.
  - timeoutErr is constant 0.

Test Plan:
- Reset release, then reqVec=0001, reqData[7:0]=0x41 -> transEnable=1 and dataToSent=0x41 on the 1st edge. Pulse charSent -> ackVec=0001 for 1 cycle. busy low after 16 GAP cycles.
- reqVec=1111 held, bytes 0x10/0x20/0x30/0x40, charSent pulsed per SEND -> grant order 0,1,2,3,0; dataToSent sequence 0x10,0x20,0x30,0x40,0x10.
- charSent held high entering SEND -> no ack until charSent goes low then high; exactly one ack.
- rst asserted 3 cycles into SEND -> transEnable=0 and busy=0 immediately. No ack. Next grant starts at requester 0.
- reqVec[2] dropped during SEND -> byte still sent, ackVec=0100 pulsed, pointer advances to 3.
- TX_TIMEOUT_EN with TIMEOUT_CYCLES=50 and no charSent -> ack on cycle 51, timeoutErr=1, and timeoutErr stays 1 through later normal transfers.
